// File: rtl/nios2_pio_edge_ctrl.sv
// Avalon-MM bidirectional PIO with per-bit direction, set/clear writes,
// synchronised inputs, sticky edge capture and a maskable level irq.
module nios2_pio_edge_ctrl #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_TYPE   = 0,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] out_oe
);

    localparam logic [2:0] PRIME_MAX = 3'(SYNC_STAGES + 1);
    localparam logic [2:0] A_DATA    = 3'd0;
    localparam logic [2:0] A_DIR     = 3'd1;
    localparam logic [2:0] A_MASK    = 3'd2;
    localparam logic [2:0] A_EDGE    = 3'd3;
    localparam logic [2:0] A_SET     = 3'd4;
    localparam logic [2:0] A_CLR     = 3'd5;

    logic             rd_strobe;
    logic             wr_strobe;
    logic [WIDTH-1:0] wdata;
    logic             unused_wdata;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] in_prev_q;
    logic [WIDTH-1:0] in_prev_d;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_det;

    logic [2:0]       prime_q;
    logic [2:0]       prime_d;
    logic             primed;

    logic [WIDTH-1:0] data_out_q;
    logic [WIDTH-1:0] data_out_d;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] dir_d;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] edgecap_d;
    logic [WIDTH-1:0] clr;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;

    assign rd_strobe    = chipselect & ~read_n;
    assign wr_strobe    = chipselect & ~write_n;
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    assign in_sync   = sync_q[SYNC_STAGES-1];
    assign in_prev_d = in_sync;
    assign rise      = in_sync & ~in_prev_q;
    assign fall      = ~in_sync & in_prev_q;
    assign primed    = (prime_q == PRIME_MAX);

    assign out_port = data_out_q;
    assign out_oe   = dir_q;
    assign readdata = readdata_q;
    assign irq      = |(edgecap_q & mask_q);

    // Synchroniser chain shift and priming counter advance.
    always_comb begin
        sync_d[0] = in_port;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prime_d = primed ? prime_q : prime_q + 3'd1;
    end

    // Select which transitions count as an edge.
    always_comb begin
        edge_det = rise;
        case (EDGE_TYPE)
            0:       edge_det = rise;
            1:       edge_det = fall;
            default: edge_det = rise | fall;
        endcase
    end

    // Register writes and sticky capture; a new edge beats a clear.
    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        mask_d     = mask_q;
        clr        = '0;
        if (wr_strobe) begin
            unique case (address)
                A_DATA:  data_out_d = wdata;
                A_DIR:   dir_d      = wdata;
                A_MASK:  mask_d     = wdata;
                A_EDGE:  clr        = wdata;
                A_SET:   data_out_d = data_out_q | wdata;
                A_CLR:   data_out_d = data_out_q & ~wdata;
                default: ;
            endcase
        end
        edgecap_d = (edgecap_q & ~clr) | (primed ? edge_det : '0);
    end

    // Read mux; readdata only changes on a read and sees pre-write values.
    always_comb begin
        readdata_d = readdata_q;
        if (rd_strobe) begin
            readdata_d = '0;
            unique case (address)
                A_DATA:  readdata_d[WIDTH-1:0] = in_sync;
                A_DIR:   readdata_d[WIDTH-1:0] = dir_q;
                A_MASK:  readdata_d[WIDTH-1:0] = mask_q;
                A_EDGE:  readdata_d[WIDTH-1:0] = edgecap_q;
                default: ;
            endcase
        end
    end

    // Input synchroniser, previous-value register and priming counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            in_prev_q <= '0;
            prime_q   <= '0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            in_prev_q <= in_prev_d;
            prime_q   <= prime_d;
        end
    end

    // Software-visible registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q <= RESET_VALUE;
            dir_q      <= '0;
            mask_q     <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            mask_q     <= mask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
        end
    end

endmodule
